axi_ram_slave: RTL and testbench
================================

Name:
axi_ram_slave

Overview:
- AXI3-style 32-bit memory responder, the target end of the interface the CPU top drives through the arbitrater.
- Used as the simulation/FPGA backing memory for the core: serves INCR burst reads (I/D cache refills) and burst/single writes (D cache writebacks, uncached stores) from one on-chip word array.
- Accepts one transaction at a time; reads and writes are serialized.

Parameters:
MEM_AW, 14, word-address width; memory holds 2^MEM_AW 32-bit words; index = addr[MEM_AW+1:2], upper address bits ignored (alias).

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  synchronous active-low reset
arid  in  4  read ID
araddr  in  32  read start byte address
arlen  in  8  read beats minus 1
arvalid  in  1  read address valid
arready  out  1  read address ready
rid  out  4  ID of the burst being returned
rdata  out  32  read data
rresp  out  2  always 2'b00
rlast  out  1  final read beat
rvalid  out  1  read data valid
rready  in  1  read data accept
awid  in  4  write ID
awaddr  in  32  write start byte address
awlen  in  8  write beats minus 1
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  master's last-beat flag
wvalid  in  1  write data valid
wready  out  1  write data ready
bid  out  4  ID of completed write
bresp  out  2  00 OKAY, 10 SLVERR on wlast mismatch
bvalid  out  1  write response valid
bready  in  1  write response accept

Behaviour:
- All data beats are 32-bit; size/burst/lock/cache/prot/wid are left unconnected at the instance. Bursts are INCR: word index +1 per beat, wrapping modulo 2^MEM_AW.
- FSM states: IDLE, RD, WR, WB.
- Reset (aresetn=0 at an edge): state is IDLE, the idle flag is 0, and the beat counter is 0. arready, awready, rvalid, rlast, wready, bvalid are all 0. rid, bid, rresp, bresp, rdata are 0. Memory contents are not reset.
- The idle flag goes to 1 the first edge after aresetn rises.
- Reset mid-burst aborts the transaction immediately: no response is issued and completed beats stay written.
- arready = idle flag. awready = idle flag and not arvalid, so a read wins over a simultaneous write.
- Read, IDLE to RD on AR handshake:
  - Latch arid and arlen, set counter to 0, and register rdata = mem[araddr index] on that same edge.
  - The next cycle has rvalid=1. First-beat latency is 1 cycle after AR acceptance.
  - While rvalid and not rready, rdata, rlast and rid hold stable.
  - On rvalid&&rready with counter != len: counter+1, and rdata is loaded with the next word on the same edge, giving zero-bubble streaming.
  - rlast = (counter == len).
  - On the last handshake, go to IDLE: rvalid drops and arready rises the following cycle.
- Write, IDLE to WR on AW handshake:
  - Latch awid and awlen, and clear the error flag. In WR, wready=1.
  - Each wvalid&&wready writes the bytes of wdata selected by wstrb to the current index. wstrb=0 writes nothing but still counts as a beat.
  - If wlast != (counter == len) on any beat, set the error flag.
  - The burst ends on the beat where counter == len, regardless of wlast. Then go to WB.
- WB: bvalid=1, bid = latched awid, bresp = error ? 2'b10 : 2'b00. On bready, go to IDLE.
- A read of an address in the cycle after a write completion returns the new data (no bypass needed; the memory array is written at the edge).
- len=0 gives a single beat, with rlast=1 on the first beat.

Decomposition:
- Shared package holds: AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, the state enum {IDLE,RD,WR,WB}, and AXI ID width 4.
- One sub-module: ram_byte_we (2^MEM_AW x 32, registered read, 4 byte write-enables).

Test Plan:
- Preload mem[0x40..0x47] with 0xA0..0xA7. AR araddr=0x100, arlen=7, arid=3, rready=1 -> 8 beats on consecutive cycles, data 0xA0..0xA7, rlast only on beat 8, rid=3, first rvalid 1 cycle after AR handshake.
- Same read with rready toggling 1/0 -> no beat lost or duplicated; rdata and rlast stable while stalled.
- AW 0x200 awlen=3 awid=5, wdata 0x11111111..0x44444444, wlast on beat 4, then read back -> bvalid with bid=5 bresp=00, readback matches.
- Single write 0xDEADBEEF wstrb=4'b0101 over 0x00000000 -> word reads 0x00AD00EF. Second case: wlast asserted on beat 2 of a 4-beat burst -> 4 beats taken, bresp=2'b10.
- arvalid and awvalid raised in the same cycle -> read handled first, awready=0 until read completes, then write proceeds.
- aresetn=0 for one edge in the middle of an 8-beat read -> next cycle all valids=0 and arready=0, then arready=1 one cycle after release.

Source files
------------

// File: rtl/axi_ram_slave_pkg.sv
// axi_ram_slave_pkg: AXI response codes, ID width and FSM state encoding shared by the RAM slave
package axi_ram_slave_pkg;
  localparam int ID_W = 4;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, RD, WR, WB} state_t;
endpackage

// File: rtl/axi_ram_slave_ram.sv
// ram_byte_we: 2^AW x 32 word array with registered read port and four byte write enables
module ram_byte_we #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-outstanding AXI3 INCR burst RAM target (AR/R read, AW/W/B write) over ram_byte_we
module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);
  state_t state, nxt;
  logic idle, err, last, ar_hs, aw_hs, r_hs, w_hs, re;
  logic [7:0] cnt, len;
  logic [ID_W-1:0] id;
  logic [MEM_AW-1:0] idx, raddr;
  logic [3:0] we;
  logic unused_addr;
  assign unused_addr = ^{araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};
  assign last = cnt == len;
  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign r_hs = rvalid && rready;
  assign w_hs = wvalid && wready;
  always_ff @(posedge aclk) state <= !aresetn ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = ar_hs ? RD : aw_hs ? WR : IDLE;
      RD:   nxt = r_hs && last ? IDLE : RD;
      WR:   nxt = w_hs && last ? WB : WR;
      WB:   nxt = bready ? IDLE : WB;
    endcase
  end
  always_comb begin
    arready = idle;
    awready = idle && !arvalid;
    rvalid = state == RD;
    rlast = state == RD && last;
    wready = state == WR;
    bvalid = state == WB;
    bresp = state == WB && err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    rresp = AXI_RESP_OKAY;
    rid = id;
    bid = id;
  end
  always_ff @(posedge aclk)
    if (!aresetn) begin
      idle <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
      len <= '0;
      id <= '0;
      idx <= '0;
    end else begin
      idle <= nxt == IDLE;
      if (ar_hs || aw_hs) begin
        id <= ar_hs ? arid : awid;
        len <= ar_hs ? arlen : awlen;
        idx <= ar_hs ? araddr[MEM_AW+1:2] : awaddr[MEM_AW+1:2];
        cnt <= '0;
      end else if ((r_hs || w_hs) && !last) begin
        cnt <= cnt + 8'd1;
        idx <= idx + MEM_AW'(1);
      end
      if (aw_hs) err <= 1'b0;
      else if (w_hs && wlast != last) err <= 1'b1;
    end
  // Prefetch the next word on each accepted non-final beat so R streams without bubbles
  assign re = ar_hs || (r_hs && !last);
  assign raddr = ar_hs ? araddr[MEM_AW+1:2] : idx + MEM_AW'(1);
  assign we = w_hs ? wstrb : 4'b0;
  ram_byte_we #(.AW(MEM_AW)) u_ram (
    .clk(aclk),
    .rst_n(aresetn),
    .re(re),
    .raddr(raddr),
    .rdata(rdata),
    .we(we),
    .waddr(idx),
    .wdata(wdata)
  );
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed stimulus with R/B scoreboard queues checked by a negedge monitor
module tb_axi_ram_slave;
  import axi_ram_slave_pkg::*;
  logic aclk = 0, aresetn = 0;
  logic [3:0] arid = 0, rid, awid = 0, bid;
  logic [31:0] araddr = 0, rdata, awaddr = 0, wdata = 0;
  logic [7:0] arlen = 0, awlen = 0;
  logic arvalid = 0, arready, rlast, rvalid, rready = 1;
  logic awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 1;
  logic [1:0] rresp, bresp;
  logic [3:0] wstrb = 0;
  always #5 aclk = ~aclk;
  axi_ram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );
  typedef struct packed { logic [31:0] d; logic l; logic [3:0] id; } r_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_t;
  r_t r_q[$];
  b_t b_q[$];
  int checks = 0, errors = 0;
  logic [31:0] wd [8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic er(input logic [31:0] d, input logic l, input logic [3:0] id);
    r_q.push_back(r_t'({d, l, id}));
  endtask
  task automatic await(input int k, input string nm);
    int n = 0;
    #1;
    while (!(k == 0 ? arready : k == 1 ? awready : k == 2 ? wready : bvalid) && n < 100) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL %s timeout", nm);
    end
  endtask
  task automatic tick;
    @(posedge aclk); #1;
  endtask
  task automatic rd(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id, input bit stall);
    int n = 0;
    araddr = a; arlen = l; arid = id; arvalid = 1; rready = 1;
    await(0, "arready");
    tick;
    arvalid = 0;
    chk("r_first_valid", rvalid, 1);
    while (r_q.size() > 0 && n < 200) begin
      if (stall) rready = ~rready;
      else chk("r_stream_valid", rvalid, 1);
      tick;
      n++;
    end
    if (n == 200) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout got %0d beats left want 0", r_q.size());
      r_q.delete();
    end
    rready = 1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                    input logic [3:0] s, input int lb, input logic [1:0] resp);
    int n = 0;
    b_q.push_back(b_t'({id, resp}));
    awaddr = a; awlen = l; awid = id; awvalid = 1;
    await(1, "awready");
    tick;
    awvalid = 0;
    for (int i = 0; i <= int'(l); i++) begin
      wdata = wd[i]; wstrb = s; wlast = i == lb; wvalid = 1;
      await(2, "wready");
      tick;
    end
    wvalid = 0; wlast = 0;
    while (b_q.size() > 0 && n < 100) begin
      tick;
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout got %0d responses left want 0", b_q.size());
      b_q.delete();
    end
  endtask
  always @(negedge aclk) begin
    if (rvalid) begin
      if (r_q.size() == 0) chk("r_unexpected", rvalid, 0);
      else begin
        chk("rdata", rdata, r_q[0].d);
        chk("rlast", rlast, r_q[0].l);
        chk("rid", rid, r_q[0].id);
        chk("rresp", rresp, AXI_RESP_OKAY);
        if (rready) void'(r_q.pop_front());
      end
    end
    if (bvalid) begin
      if (b_q.size() == 0) chk("b_unexpected", bvalid, 0);
      else begin
        chk("bid", bid, b_q[0].id);
        chk("bresp", bresp, b_q[0].resp);
        if (bready) void'(b_q.pop_front());
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rdata", rdata, 0);
    aresetn = 1;
    #1 chk("rel_arready_early", arready, 0);
    tick;
    chk("rel_arready", arready, 1);
    // preload words 0x40..0x47 and stream them back
    for (int i = 0; i < 8; i++) wd[i] = 32'hA0 + i;
    wr(32'h100, 7, 1, 4'hF, 7, AXI_RESP_OKAY);
    for (int i = 0; i < 8; i++) er(32'hA0 + i, i == 7, 3);
    rd(32'h100, 7, 3, 0);
    for (int i = 0; i < 8; i++) er(32'hA0 + i, i == 7, 3);
    rd(32'h100, 7, 3, 1);
    // 4-beat write then readback
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
    wr(32'h200, 3, 5, 4'hF, 3, AXI_RESP_OKAY);
    er(32'h11111111, 0, 2); er(32'h22222222, 0, 2); er(32'h33333333, 0, 2); er(32'h44444444, 1, 2);
    rd(32'h200, 3, 2, 0);
    // index wraps from the top word to word 0; upper address bits alias
    wd[0] = 32'h12345678; wd[1] = 32'h9ABCDEF0;
    wr(32'hFFFC, 1, 4, 4'hF, 1, AXI_RESP_OKAY);
    er(32'h12345678, 0, 9); er(32'h9ABCDEF0, 1, 9);
    rd(32'hFFFC, 1, 9, 0);
    er(32'h9ABCDEF0, 1, 9);
    rd(32'h0001_0000, 0, 9, 0);
    // byte strobes over a zeroed word
    wd[0] = 32'h0;
    wr(32'h0, 0, 2, 4'hF, 0, AXI_RESP_OKAY);
    wd[0] = 32'hDEADBEEF;
    wr(32'h0, 0, 2, 4'b0101, 0, AXI_RESP_OKAY);
    er(32'h00AD00EF, 1, 4);
    rd(32'h0, 0, 4, 0);
    // early wlast: all four beats still taken, SLVERR reported
    wd[0] = 32'h60606060; wd[1] = 32'h61616161; wd[2] = 32'h62626262; wd[3] = 32'h63636363;
    wr(32'h300, 3, 6, 4'hF, 1, AXI_RESP_SLVERR);
    er(32'h60606060, 0, 6); er(32'h61616161, 0, 6); er(32'h62626262, 0, 6); er(32'h63636363, 1, 6);
    rd(32'h300, 3, 6, 0);
    // simultaneous AR and AW: read first, write held off
    araddr = 32'h100; arlen = 1; arid = 7; arvalid = 1;
    awaddr = 32'h400; awlen = 0; awid = 8; awvalid = 1;
    er(32'hA0, 0, 7); er(32'hA1, 1, 7);
    #1;
    chk("sim_arready", arready, 1);
    chk("sim_awready_blocked", awready, 0);
    tick;
    arvalid = 0;
    for (int n = 0; n < 20 && r_q.size() > 0; n++) begin
      chk("sim_awready_during_rd", awready, 0);
      tick;
    end
    chk("sim_rd_done", r_q.size(), 0);
    wd[0] = 32'hCAFEF00D;
    wr(32'h400, 0, 8, 4'hF, 0, AXI_RESP_OKAY);
    er(32'hCAFEF00D, 1, 8);
    rd(32'h400, 0, 8, 0);
    // reset in the middle of an 8-beat read
    for (int i = 0; i < 8; i++) er(32'hA0 + i, i == 7, 3);
    araddr = 32'h100; arlen = 7; arid = 3; arvalid = 1; rready = 1;
    await(0, "arready_mid");
    tick;
    arvalid = 0;
    repeat (3) tick;
    aresetn = 0;
    tick;
    r_q.delete();
    chk("mid_rvalid", rvalid, 0);
    chk("mid_bvalid", bvalid, 0);
    chk("mid_wready", wready, 0);
    chk("mid_arready", arready, 0);
    chk("mid_awready", awready, 0);
    aresetn = 1;
    #1 chk("mid_arready_held", arready, 0);
    tick;
    chk("mid_arready_back", arready, 1);
    er(32'hA5, 1, 3);
    rd(32'h114, 0, 3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
